// File: rtl/coa_pkg.sv
// Shared constants for the COA lab datapath: FSM state encoding and default operand width.
package coa_pkg;
    localparam int DEFAULT_WIDTH = 8;
    localparam int RCA_W         = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/rca_shift_add_mult_if.sv
// Start/operand request and busy/done/product result bundle for the shift-add multiplier.
interface rca_shift_add_mult_if #(parameter int WIDTH = 8) ();
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/rca.sv
// Ripple-carry adder: sum = a + b + c_in.
// Purely combinational, no backpressure.
module rca #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             c_out,
    output logic [WIDTH-1:0] sum
);
    logic carry;

    always_comb begin
        carry = c_in;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        c_out = carry;
    end
endmodule

// File: rtl/rca_shift_add_mult.sv
// Sequential unsigned WIDTHxWIDTH multiplier built on the rca adder, one add+shift per clock.
// Latency: done pulses WIDTH edges after start is accepted; product held until next accept.
// Backpressure: start is only sampled in IDLE; requests during RUN/DONE are dropped.
module rca_shift_add_mult
    import coa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    rca_shift_add_mult_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    if (WIDTH != RCA_W) begin : g_bad_width
        $error("rca_shift_add_mult: WIDTH must match the rca width");
    end

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [WIDTH-1:0]   m_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   q_q;
    logic               c_q;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]   sum;
    logic               c_out;
    logic [2*WIDTH:0]   step_val;
    logic               accept;

    rca #(.WIDTH(WIDTH)) u_rca (
        .a     (a_q),
        .b     (m_q),
        .c_in  (1'b0),
        .c_out (c_out),
        .sum   (sum)
    );

    assign accept = (state_q == ST_IDLE) && bus.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN:  if (count_q == CNT_W'(1)) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == ST_RUN);
        bus.done = (state_q == ST_DONE);
    end

    // C is always zero after a shift, so the no-add branch is {0,A,Q} >> 1.
    always_comb begin
        if (q_q[0]) begin
            step_val = {c_out, sum, q_q} >> 1;
        end else begin
            step_val = {c_q, a_q, q_q} >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            c_q     <= 1'b0;
            count_q <= '0;
        end else if (accept) begin
            m_q     <= bus.multiplicand;
            q_q     <= bus.multiplier;
            a_q     <= '0;
            c_q     <= 1'b0;
            count_q <= CNT_W'(WIDTH);
        end else if (state_q == ST_RUN) begin
            {c_q, a_q, q_q} <= step_val;
            count_q         <= count_q - CNT_W'(1);
        end
    end

    assign bus.product = {a_q, q_q};
endmodule

// File: tb/tb_rca_shift_add_mult.sv
// Bench for rca_shift_add_mult: directed jobs with literal results plus a cycle-level
// reference model (acceptance timeline + integer product) compared on every clock.
module tb_rca_shift_add_mult;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 0;

    rca_shift_add_mult_if #(.WIDTH(W)) bus ();

    rca_shift_add_mult #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: age counts edges since acceptance; busy for ages 0..W-1, done at age W,
    // idle (and able to accept) once age exceeds W.
    bit              m_active;
    int              m_age;
    logic [2*W-1:0]  m_pending;
    logic [2*W-1:0]  m_prod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active  = 0;
            m_age     = 0;
            m_pending = '0;
            m_prod    = '0;
        end else if ((!m_active || m_age > W) && bus.start === 1'b1) begin
            m_active  = 1;
            m_age     = 0;
            m_pending = 16'(int'(bus.multiplicand) * int'(bus.multiplier));
        end else if (m_active) begin
            m_age++;
            if (m_age == W) m_prod = m_pending;
        end
    end

    always @(posedge clk) begin
        #2;
        if (cmp_en) begin
            chk("model_busy", 32'(bus.busy), 32'(m_active && m_age < W));
            chk("model_done", 32'(bus.done), 32'(m_active && m_age == W));
            if (!(m_active && m_age < W)) chk("model_product", 32'(bus.product), 32'(m_prod));
        end
    end

    // Launch a job and return how many negedges (first one after the accept edge = 1) until done.
    task automatic run_job(input logic [7:0] m, input logic [7:0] q, output int lat);
        lat = 0;
        @(negedge clk);
        bus.start = 1; bus.multiplicand = m; bus.multiplier = q;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.start = 0;
                bus.multiplicand = 8'($urandom);
                bus.multiplier   = 8'($urandom);
            end
            if (bus.done) lat = i;
        end
    endtask

    task automatic directed(input string name, input logic [7:0] m, input logic [7:0] q,
                            input logic [15:0] exp);
        int lat;
        run_job(m, q, lat);
        chk({name, "_latency"}, 32'(lat), 32'd9);
        chk({name, "_busy_in_done"}, 32'(bus.busy), 32'd0);
        chk({name, "_product"}, 32'(bus.product), 32'(exp));
    endtask

    initial begin
        int lat;
        int d1;
        int d2;
        rst_n = 0;
        bus.start = 0; bus.multiplicand = '0; bus.multiplier = '0;
        #1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_product", 32'(bus.product), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        cmp_en = 1;

        directed("mul_2x3", 8'd2, 8'd3, 16'd6);
        directed("mul_255x255", 8'd255, 8'd255, 16'hFE01);
        directed("mul_0x200", 8'd0, 8'd200, 16'd0);
        directed("mul_13x0", 8'd13, 8'd0, 16'd0);

        // Retrigger: starts mid-RUN and during DONE must be ignored.
        lat = 0;
        @(negedge clk);
        bus.start = 1; bus.multiplicand = 8'd7; bus.multiplier = 8'd9;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            bus.start = (i == 3);
            if (i == 3) begin bus.multiplicand = 8'd1; bus.multiplier = 8'd1; end
            if (bus.done) begin
                lat = i;
                bus.start = 1; bus.multiplicand = 8'd2; bus.multiplier = 8'd2;
            end
        end
        chk("retrig_latency", 32'(lat), 32'd9);
        chk("retrig_product_done", 32'(bus.product), 32'd63);
        @(negedge clk);
        bus.start = 0;
        chk("retrig_product_after", 32'(bus.product), 32'd63);
        chk("retrig_not_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("retrig_still_idle", 32'(bus.busy), 32'd0);

        // Held start: back-to-back jobs, second accepted on the first IDLE edge.
        d1 = 0; d2 = 0;
        @(negedge clk);
        bus.start = 1; bus.multiplicand = 8'd3; bus.multiplier = 8'd5;
        for (int i = 1; i <= 40 && d2 == 0; i++) begin
            @(negedge clk);
            if (i == 1) begin bus.multiplicand = 8'd4; bus.multiplier = 8'd6; end
            if (bus.done) begin
                if (d1 == 0) begin
                    d1 = i;
                    chk("hold_first_product", 32'(bus.product), 32'd15);
                end else begin
                    d2 = i;
                    bus.start = 0;
                    chk("hold_second_product", 32'(bus.product), 32'd24);
                end
            end
        end
        chk("hold_first_latency", 32'(d1), 32'd9);
        chk("hold_done_gap", 32'(d2 - d1), 32'd10);

        // Asynchronous reset in the middle of a 100 x 50 job.
        @(negedge clk);
        bus.start = 1; bus.multiplicand = 8'd100; bus.multiplier = 8'd50;
        @(negedge clk);
        bus.start = 0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 0;
        #1;
        chk("async_reset_busy", 32'(bus.busy), 32'd0);
        chk("async_reset_done", 32'(bus.done), 32'd0);
        chk("async_reset_product", 32'(bus.product), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        directed("mul_100x50", 8'd100, 8'd50, 16'd5000);

        for (int n = 0; n < 500; n++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom);
            b = 8'($urandom);
            run_job(a, b, lat);
            chk("rand_latency", 32'(lat), 32'd9);
            chk("rand_product", 32'(bus.product), 32'(int'(a) * int'(b)));
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
